// File: rtl/conv_pkg.sv
// Shared parameters, state encoding and width helper for the 3x3 convolution MAC controller.
package conv_pkg;

    localparam int DATA_W = 16;
    localparam int N_TAPS = 9;
    localparam int ADDR_W = 4;

    // Accumulator width: full product width plus enough guard bits for N_TAPS additions.
    function automatic int calc_acc_w(input int data_w, input int n_taps);
        return 2 * data_w + $clog2(n_taps);
    endfunction

    localparam int ACC_W = calc_acc_w(DATA_W, N_TAPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/conv_mac_pipe.sv
// Sample / multiply / accumulate datapath.
// Stage 1 aligns the valid/last flags with the RAM read data (one cycle after
// the read enable), stage 2 registers the signed product, stage 3 accumulates.
// out_vld is high in the cycle the last product is being added, so the final
// sum is on acc in the following cycle.
module conv_mac_pipe
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic              last,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              acc_clr,
    output logic [ACC_W-1:0]  acc,
    output logic              out_vld
);

    logic                       s1_vld;
    logic                       s1_last;
    logic                       p_vld;
    logic                       p_last;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;

    assign a_ext   = signed'({{DATA_W{a[DATA_W-1]}}, a});
    assign b_ext   = signed'({{DATA_W{b[DATA_W-1]}}, b});
    assign out_vld = p_vld && p_last;

    // Stage 1: read data becomes valid one cycle after the read enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
        end else begin
            s1_vld  <= in_vld;
            s1_last <= in_vld && last;
        end
    end

    // Stage 2: registered signed product of the sampled data and weight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld  <= 1'b0;
            p_last <= 1'b0;
            prod   <= '0;
        end else begin
            p_vld  <= s1_vld;
            p_last <= s1_vld && s1_last;
            if (s1_vld) begin
                prod <= a_ext * b_ext;
            end
        end
    end

    // Stage 3: accumulate sign-extended products; clear wins over add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (p_vld) begin
            acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/conv3x3_mac_ctrl.sv
// 3x3 window MAC controller: reads N_TAPS data/weight pairs, accumulates their
// signed products and hands one result downstream with valid/ready.
// Optional build macro CONV_RELU_EN clamps negative results to zero.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing reads to addresses 0..N_TAPS-1
// DRAIN | reads done, waiting for the last product to be accumulated
// OUT   | result_vld held until result_rdy
module conv3x3_mac_ctrl
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              data_rd_en,
    output logic [ADDR_W-1:0] data_rd_addr,
    input  logic [DATA_W-1:0] data_rd_data,
    output logic              wgt_rd_en,
    output logic [ADDR_W-1:0] wgt_rd_addr,
    input  logic [DATA_W-1:0] wgt_rd_data,
    output logic              result_vld,
    input  logic              result_rdy,
    output logic [ACC_W-1:0]  result
);

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic               rd_en;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_out;
    logic [ACC_W-1:0]   result_q;
    logic               acc_clr;
    logic               last_tap;
    logic               done;

    assign busy         = (state != IDLE);
    assign data_rd_en   = rd_en;
    assign wgt_rd_en    = rd_en;
    assign data_rd_addr = addr;
    assign wgt_rd_addr  = addr;
    assign acc_clr      = (state == IDLE) && start;
    assign last_tap     = (addr == ADDR_W'(N_TAPS - 1));

    // While presenting, result tracks the (now stable) accumulator; afterwards
    // the captured copy is kept so a new run's accumulator clear is invisible.
    assign result = result_vld ? acc_out : result_q;

    // Output shaping of the accumulator.
    always_comb begin
        acc_out = acc;
`ifdef CONV_RELU_EN
        if (acc[ACC_W-1]) begin
            acc_out = '0;
        end
`endif
    end

    conv_mac_pipe u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd_en),
        .last    (rd_en && last_tap),
        .a       (data_rd_data),
        .b       (wgt_rd_data),
        .acc_clr (acc_clr),
        .acc     (acc),
        .out_vld (done)
    );

    // Sequencing FSM with read address counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            rd_en      <= 1'b0;
            result_vld <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        rd_en <= 1'b1;
                        addr  <= '0;
                    end
                end
                READ: begin
                    if (last_tap) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                        addr  <= '0;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state      <= OUT;
                        result_vld <= 1'b1;
                    end
                end
                OUT: begin
                    if (result_rdy) begin
                        state      <= IDLE;
                        result_vld <= 1'b0;
                        result_q   <= acc_out;
                    end
                end
                default: begin
                    state      <= IDLE;
                    rd_en      <= 1'b0;
                    addr       <= '0;
                    result_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_mac_ctrl.sv
// Self-checking bench for conv3x3_mac_ctrl: table vectors, random windows
// against a sum-of-products model, plus backpressure and mid-read reset cases.
module tb_conv3x3_mac_ctrl;

    localparam int DW = 16;
    localparam int NT = 9;
    localparam int AW = 4;
    localparam int RW = 36;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          data_rd_en;
    logic [AW-1:0] data_rd_addr;
    logic [DW-1:0] data_rd_data;
    logic          wgt_rd_en;
    logic [AW-1:0] wgt_rd_addr;
    logic [DW-1:0] wgt_rd_data;
    logic          result_vld;
    logic          result_rdy;
    logic [RW-1:0] result;

    logic [DW-1:0] dmem [NT];
    logic [DW-1:0] wmem [NT];

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [NT*DW-1:0] d;
        logic [NT*DW-1:0] w;
        logic [RW-1:0]    exp;
    } vec_t;

    vec_t vecs [4];

    conv3x3_mac_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .data_rd_en   (data_rd_en),
        .data_rd_addr (data_rd_addr),
        .data_rd_data (data_rd_data),
        .wgt_rd_en    (wgt_rd_en),
        .wgt_rd_addr  (wgt_rd_addr),
        .wgt_rd_data  (wgt_rd_data),
        .result_vld   (result_vld),
        .result_rdy   (result_rdy),
        .result       (result)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM models: data valid one cycle after rd_en.
    always @(posedge clk) begin
        if (data_rd_en) data_rd_data <= dmem[data_rd_addr];
        if (wgt_rd_en)  wgt_rd_data  <= wmem[wgt_rd_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain signed sum of products, optional clamp.
    function automatic logic [RW-1:0] model();
        longint sum = 0;
        logic [63:0] s;
        for (int i = 0; i < NT; i++) begin
            sum += longint'($signed(dmem[i])) * longint'($signed(wmem[i]));
        end
`ifdef CONV_RELU_EN
        if (sum < 0) sum = 0;
`endif
        s = sum;
        return s[RW-1:0];
    endfunction

    // One full transaction with result_rdy high; checks reads, latency, value.
    task automatic run_conv(input logic [RW-1:0] exp, input string name);
        int  cyc;
        int  nrd;
        bit  seen;
        bit  addr_ok;
        start = 1'b1;
        result_rdy = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        nrd = 0;
        seen = 1'b0;
        addr_ok = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (data_rd_en) begin
                if (data_rd_addr != AW'(nrd) || wgt_rd_addr != AW'(nrd) || !wgt_rd_en || cyc != nrd + 1)
                    addr_ok = 1'b0;
                nrd++;
            end
            if (result_vld) seen = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        chk({name, " vld_seen"}, 64'(seen), 64'd1);
        chk({name, " latency"}, 64'(cyc), 64'd12);
        chk({name, " n_reads"}, 64'(nrd), 64'd9);
        chk({name, " addr_seq"}, 64'(addr_ok), 64'd1);
        chk({name, " result"}, 64'(result), 64'(exp));
        step();
        chk({name, " idle_busy"}, 64'(busy), 64'd0);
        chk({name, " idle_vld"}, 64'(result_vld), 64'd0);
        chk({name, " kept_result"}, 64'(result), 64'(exp));
    endtask

    initial begin
        int  bad;
        bit  seen;
        rst_n = 1'b0;
        start = 1'b0;
        result_rdy = 1'b0;
        for (int i = 0; i < NT; i++) begin
            dmem[i] = '0;
            wmem[i] = '0;
        end
        step();
        step();
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst rd_en", 64'({data_rd_en, wgt_rd_en}), 64'd0);
        chk("rst addr", 64'({data_rd_addr, wgt_rd_addr}), 64'd0);
        chk("rst vld", 64'(result_vld), 64'd0);
        chk("rst result", 64'(result), 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < NT; i++) begin
            vecs[0].d[i*DW +: DW] = 16'd1;
            vecs[0].w[i*DW +: DW] = 16'd1;
            vecs[1].d[i*DW +: DW] = 16'(i + 1);
            vecs[1].w[i*DW +: DW] = (i % 2 == 0) ? 16'h0001 : 16'hFFFF;
            vecs[2].d[i*DW +: DW] = 16'h8000;
            vecs[2].w[i*DW +: DW] = 16'h8000;
            vecs[3].d[i*DW +: DW] = 16'hFFFF;
            vecs[3].w[i*DW +: DW] = 16'h0001;
        end
        vecs[0].exp = 36'd9;
        vecs[1].exp = 36'd5;
        vecs[2].exp = 36'h240000000;
`ifdef CONV_RELU_EN
        vecs[3].exp = 36'd0;
`else
        vecs[3].exp = 36'hFFFFFFFF7;
`endif

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < NT; i++) begin
                dmem[i] = vecs[v].d[i*DW +: DW];
                wmem[i] = vecs[v].w[i*DW +: DW];
            end
            run_conv(vecs[v].exp, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NT; i++) begin
                dmem[i] = 16'($urandom);
                wmem[i] = 16'($urandom);
            end
            run_conv(model(), $sformatf("rand%0d", r));
        end

        // Backpressure: result held for 20 cycles while start keeps pulsing.
        for (int i = 0; i < NT; i++) begin
            dmem[i] = 16'd1;
            wmem[i] = 16'd1;
        end
        result_rdy = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (result_vld) seen = 1'b1;
            else step();
        end
        chk("hold vld_seen", 64'(seen), 64'd1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            start = k[0];
            if (!result_vld || result != 36'd9 || !busy || data_rd_en || wgt_rd_en) bad++;
            step();
        end
        chk("hold stable_cycles_bad", 64'(bad), 64'd0);
        result_rdy = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("hold release_busy", 64'(busy), 64'd0);
        chk("hold release_vld", 64'(result_vld), 64'd0);
        chk("hold release_result", 64'(result), 64'd9);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (data_rd_en || busy) bad++;
            step();
        end
        chk("hold no_restart", 64'(bad), 64'd0);

        // Reset in the 5th READ cycle, then a clean run.
        for (int i = 0; i < NT; i++) begin
            dmem[i] = 16'(i + 1);
            wmem[i] = 16'd2;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid addr_before_rst", 64'(data_rd_addr), 64'd4);
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", 64'(busy), 64'd0);
        chk("mid rst rd_en", 64'({data_rd_en, wgt_rd_en}), 64'd0);
        chk("mid rst addr", 64'({data_rd_addr, wgt_rd_addr}), 64'd0);
        chk("mid rst vld", 64'(result_vld), 64'd0);
        chk("mid rst result", 64'(result), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        run_conv(36'd90, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv3x3_mac_ctrl.md
Name: conv3x3_mac_ctrl

Overview:
Downstream consumer of the data RAM and weight RAM filled by the write controllers. On a start pulse it reads the 9 elements of the 3x3 window from each RAM, one 16-bit element per cycle. It multiplies each data element by the matching weight element as signed values and accumulates the products. It then presents one result word to the next stage with a valid/ready handshake.

Parameters:
DATA_W, 16, signed element width of one RAM read lane
N_TAPS, 9, number of window elements; reads use addresses 0..N_TAPS-1
ADDR_W, 4, RAM read address width
ACC_W, 36, accumulator/result width (2*DATA_W + 4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse, window loaded in both RAMs
busy  out  1  high whenever the state is not IDLE
data_rd_en  out  1  data RAM read enable
data_rd_addr  out  ADDR_W  data RAM read address
data_rd_data  in  DATA_W  data RAM read data, valid 1 cycle after rd_en
wgt_rd_en  out  1  weight RAM read enable
wgt_rd_addr  out  ADDR_W  weight RAM read address
wgt_rd_data  in  DATA_W  weight RAM read data, valid 1 cycle after rd_en
result_vld  out  1  result valid
result_rdy  in  1  downstream ready
result  out  ACC_W  signed accumulated sum

Behaviour:
- Reset: state IDLE. busy, rd_en, rd_addr, result_vld and result are all 0. Pipeline valids, product register and accumulator are cleared.
- The reset is asynchronous and aborts any operation in progress. The next access after release starts from IDLE.
- States: IDLE, READ, DRAIN, OUT.
- IDLE: start=1 moves to READ. start is ignored in every other state; it is neither queued nor counted.
- READ: both rd_en signals are high. The two addresses are equal and registered, starting at 0 in the first READ cycle and incrementing by 1 each cycle.
- READ exits to DRAIN after the cycle with address N_TAPS-1. rd_en is then 0 and rd_addr returns to 0.
- Pipeline:
  - stage 1 samples the read data 1 cycle after rd_en;
  - stage 2 holds the registered signed product, 2*DATA_W bits;
  - stage 3 is the accumulator, which adds the sign-extended product.
- The accumulator is cleared at entry to READ. No saturation is needed: 9*2^30 is below 2^35.
- DRAIN: waits until the last product has been accumulated, then moves to OUT.
- OUT: result_vld=1 and result holds the accumulator. Both are held stable until result_vld && result_rdy. The state then returns to IDLE, with result_vld=0 and result kept until the next final accumulation.
- Latency: start in cycle 0 gives rd_en in cycles 1..9 and result_vld first high in cycle 12, i.e. N_TAPS+3.
- result_rdy may already be high on entry to OUT. The handshake then completes in that cycle and the state is back in IDLE the following cycle.
- A start coinciding with the OUT handshake cycle is ignored, because busy is still 1 in that cycle. The minimum start spacing is therefore N_TAPS+4 cycles.
- Read-data inputs are don't-care when no read is pending.

Optional Feature:
CONV_RELU_EN
- Defined: result = 0 when the accumulator is negative, otherwise the accumulator. Timing is unchanged.
- Undefined: result is the raw signed accumulator.

Decomposition:
- Package conv_pkg holds:
  - DATA_W, N_TAPS, ADDR_W, ACC_W;
  - the state enum (IDLE, READ, DRAIN, OUT);
  - the function that derives ACC_W from DATA_W and N_TAPS.
- Sub-module conv_mac_pipe contains the 3-stage sample/multiply/accumulate datapath. Its interface is: in_vld, a, b, acc_clr, acc, out_vld on last.
- The FSM and address counter stay in the top module.

Test Plan:
- All 9 data = 1 and all weights = 1, start, result_rdy=1 -> result_vld in cycle 12, result = 9, rd_addr sequence 0..8.
- Data k+1 (1..9) with weights alternating +1/-1, starting at +1 -> result = 1-2+3-4+5-6+7-8+9 = 5.
- All data and weights = 0x8000 (-32768) -> result = 0x240000000 (9*2^30), with no wrap.
- Data all -1 and weights all 1 -> without CONV_RELU_EN result = -9 (all ones above 0x...FFF7); with CONV_RELU_EN result = 0.
- Hold result_rdy=0 for 20 cycles in OUT, pulsing start repeatedly -> result_vld and result stay stable, busy=1, no new reads issued; raise rdy -> one handshake, then IDLE.
- Assert rst_n=0 in the 5th READ cycle -> all outputs 0 immediately. After release, start -> a full clean read of addresses 0..8 and the correct result.
